// File: rtl/ucie_ctl_sb_pkg.sv
// Shared definitions for the sideband TX control path.
//  - Header field positions (within each 32-bit phase)
//  - Encoder FSM state encodings
//  - Default source/destination IDs
package ucie_ctl_sb_pkg;

    // Default endpoint IDs: local and remote D2D adapter.
    localparam logic [2:0] SRC_ID_DEFAULT = 3'b001;
    localparam logic [2:0] DST_ID_DEFAULT = 3'b101;

    // Phase 0 field positions.
    localparam int unsigned OPCODE_LSB  = 0;
    localparam int unsigned OPCODE_MSB  = 4;
    localparam int unsigned MSGCODE_LSB = 14;
    localparam int unsigned MSGCODE_MSB = 21;
    localparam int unsigned SRCID_LSB   = 27;
    localparam int unsigned SRCID_MSB   = 29;

    // Phase 1 field positions.
    localparam int unsigned SUBCODE_LSB = 0;
    localparam int unsigned SUBCODE_MSB = 7;
    localparam int unsigned INFO_LSB    = 8;
    localparam int unsigned INFO_MSB    = 23;
    localparam int unsigned DSTID_LSB   = 24;
    localparam int unsigned DSTID_MSB   = 26;
    localparam int unsigned DP_BIT      = 30;
    localparam int unsigned CP_BIT      = 31;

    // Encoder FSM states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_HDR  = 2'd2;
    localparam logic [1:0] ST_DATA = 2'd3;

endpackage

// File: rtl/ucie_ctl_sb_parity_gen.sv
// Sideband header parity generator (purely combinational).
//  data      in   64  payload
//  with_data in   1   payload present; DP forced to 0 otherwise
//  hdr       in   63  header bits {phase1[30:0], phase0} with the DP slot (bit 62) at 0
//  dp        out  1   data parity
//  cp        out  1   control parity, covering the header including DP
module ucie_ctl_sb_parity_gen (
    input  logic [63:0] data,
    input  logic        with_data,
    input  logic [62:0] hdr,
    output logic        dp,
    output logic        cp
);

    always_comb begin
        dp = with_data ? ^data : 1'b0;
        // DP slot arrives as 0, so folding dp in here equals parity over the final header bits.
        cp = (^hdr) ^ dp;
    end

endmodule

// File: rtl/ucie_ctl_sb_header_encoder.sv
// Sideband TX message encoder.
// Captures a message request, drives the code register-file read addresses, assembles a
// 64-bit sideband header with parity from the returned codes, and streams the header
// (plus an optional data beat) to the serializer over valid/ready.
//  i_clk / i_rst                clock, asynchronous active-low reset
//  i_msg_valid / o_msg_ready    request handshake (ready only while idle)
//  i_msg_sel, i_sub_sel         msg-code / subcode indices
//  i_with_data, i_data          optional 64-bit payload
//  o_*_addr                     register-file read addresses
//  i_*_code                     register-file read data (combinational)
//  o_pckt / o_pckt_valid        beat stream, i_pckt_ready from downstream
//  o_busy                       FSM not idle
module ucie_ctl_sb_header_encoder
    import ucie_ctl_sb_pkg::*;
#(
    parameter logic [2:0] SRC_ID = SRC_ID_DEFAULT,
    parameter logic [2:0] DST_ID = DST_ID_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_msg_valid,
    output logic        o_msg_ready,
    input  logic [1:0]  i_msg_sel,
    input  logic [1:0]  i_sub_sel,
    input  logic        i_with_data,
    input  logic [63:0] i_data,
    output logic        o_op_addr,
    output logic [1:0]  o_msg_addr,
    output logic [1:0]  o_sub_addr,
    output logic        o_info_addr,
    input  logic [4:0]  i_op_code,
    input  logic [7:0]  i_msg_code,
    input  logic [7:0]  i_sub_code,
    input  logic [15:0] i_info_code,
    output logic [63:0] o_pckt,
    output logic        o_pckt_valid,
    input  logic        i_pckt_ready,
    output logic        o_busy
);

    logic [1:0]  state_q, state_d;
    logic [1:0]  msg_sel_q, sub_sel_q;
    logic        with_data_q;
    logic [63:0] data_q;
    logic [63:0] pckt_q, pckt_d;
    logic        pckt_valid_q, pckt_valid_d;
    logic        capture;

    logic [31:0] phase0, phase1;
    logic [63:0] header;
    logic        dp, cp;

    // Request capture; addresses come straight from these registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            msg_sel_q   <= '0;
            sub_sel_q   <= '0;
            with_data_q <= 1'b0;
            data_q      <= '0;
        end else if (capture) begin
            msg_sel_q   <= i_msg_sel;
            sub_sel_q   <= i_sub_sel;
            with_data_q <= i_with_data;
            data_q      <= i_data;
        end
    end

    assign o_op_addr   = with_data_q;
    assign o_msg_addr  = msg_sel_q;
    assign o_sub_addr  = sub_sel_q;
    assign o_info_addr = 1'b0;

    // Header assembly from the register-file codes; valid during LOAD.
    always_comb begin
        phase0 = '0;
        phase0[OPCODE_MSB:OPCODE_LSB]   = i_op_code;
        phase0[MSGCODE_MSB:MSGCODE_LSB] = i_msg_code;
        phase0[SRCID_MSB:SRCID_LSB]     = SRC_ID;

        phase1 = '0;
        phase1[SUBCODE_MSB:SUBCODE_LSB] = i_sub_code;
        phase1[INFO_MSB:INFO_LSB]       = i_info_code;
        phase1[DSTID_MSB:DSTID_LSB]     = DST_ID;
    end

    ucie_ctl_sb_parity_gen u_parity_gen (
        .data      (data_q),
        .with_data (with_data_q),
        .hdr       ({phase1[30:0], phase0}),
        .dp        (dp),
        .cp        (cp)
    );

    always_comb begin
        header         = {phase1, phase0};
        header[32 + DP_BIT] = dp;
        header[32 + CP_BIT] = cp;
    end

    // FSM next state and beat register.
    always_comb begin
        state_d      = state_q;
        pckt_d       = pckt_q;
        pckt_valid_d = pckt_valid_q;
        capture      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_msg_valid) begin
                    capture = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                pckt_d       = header;
                pckt_valid_d = 1'b1;
                state_d      = ST_HDR;
            end
            ST_HDR: begin
                if (i_pckt_ready) begin
                    if (with_data_q) begin
                        pckt_d  = data_q;
                        state_d = ST_DATA;
                    end else begin
                        pckt_d       = '0;
                        pckt_valid_d = 1'b0;
                        state_d      = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (i_pckt_ready) begin
                    pckt_d       = '0;
                    pckt_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                pckt_d       = '0;
                pckt_valid_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= ST_IDLE;
            pckt_q       <= '0;
            pckt_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pckt_q       <= pckt_d;
            pckt_valid_q <= pckt_valid_d;
        end
    end

    assign o_pckt       = pckt_q;
    assign o_pckt_valid = pckt_valid_q;
    assign o_msg_ready  = (state_q == ST_IDLE);
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ucie_ctl_sb_header_encoder.sv
// Self-checking bench for ucie_ctl_sb_header_encoder.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the falling edge.
// A scoreboard queue holds the expected beats; a monitor pops them on each handshake.
module tb_ucie_ctl_sb_header_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        msg_valid = 1'b0;
    logic        msg_ready;
    logic [1:0]  msg_sel = '0;
    logic [1:0]  sub_sel = '0;
    logic        with_data = 1'b0;
    logic [63:0] data = '0;
    logic        op_addr;
    logic [1:0]  msg_addr, sub_addr;
    logic        info_addr;
    logic [4:0]  op_code;
    logic [7:0]  msg_code, sub_code;
    logic [15:0] info_code;
    logic [63:0] pckt;
    logic        pckt_valid;
    logic        pckt_ready = 1'b1;
    logic        busy;

    // Register-file model
    logic [4:0]  op_rom  [2];
    logic [7:0]  msg_rom [4];
    logic [7:0]  sub_rom [4];
    logic [15:0] info_val = 16'h0000;

    assign op_code   = op_rom[op_addr];
    assign msg_code  = msg_rom[msg_addr];
    assign sub_code  = sub_rom[sub_addr];
    assign info_code = info_addr ? 16'hFFFF : info_val;

    int vectors = 0;
    int miscompares = 0;
    int beats = 0;
    int cyc = 0;
    logic [63:0] sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    ucie_ctl_sb_header_encoder dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_msg_valid  (msg_valid),
        .o_msg_ready  (msg_ready),
        .i_msg_sel    (msg_sel),
        .i_sub_sel    (sub_sel),
        .i_with_data  (with_data),
        .i_data       (data),
        .o_op_addr    (op_addr),
        .o_msg_addr   (msg_addr),
        .o_sub_addr   (sub_addr),
        .o_info_addr  (info_addr),
        .i_op_code    (op_code),
        .i_msg_code   (msg_code),
        .i_sub_code   (sub_code),
        .i_info_code  (info_code),
        .o_pckt       (pckt),
        .o_pckt_valid (pckt_valid),
        .i_pckt_ready (pckt_ready),
        .o_busy       (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_hdr(input logic [1:0] m, input logic [1:0] s,
                                            input logic w, input logic [63:0] d);
        logic [31:0] p0, p1;
        p0 = '0;
        p0[4:0]   = op_rom[w];
        p0[21:14] = msg_rom[m];
        p0[29:27] = 3'b001;
        p1 = '0;
        p1[7:0]   = sub_rom[s];
        p1[23:8]  = info_val;
        p1[26:24] = 3'b101;
        p1[30]    = w ? ^d : 1'b0;
        p1[31]    = ^{p1[30:0], p0};
        return {p1, p0};
    endfunction

    // Scoreboard monitor: a beat is transferred at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && pckt_valid && pckt_ready) begin
            vectors++;
            assert (sb_q.size() > 0) else begin
                miscompares++;
                $error("FAIL unexpected_beat: observed %h expected no beat", pckt);
            end
            if (sb_q.size() > 0) chk("beat", pckt, sb_q.pop_front());
            beats++;
        end
    end

    // Present one request to an idle DUT; returns 1 ns after the accepting edge.
    task automatic issue(input logic [1:0] m, input logic [1:0] s, input logic w,
                         input logic [63:0] d);
        msg_valid = 1'b1;
        msg_sel   = m;
        sub_sel   = s;
        with_data = w;
        data      = d;
        sb_q.push_back(exp_hdr(m, s, w, d));
        if (w) sb_q.push_back(d);
        @(posedge clk); #1;
        msg_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int b0;
        int prev;
        int acc;
        int n;
        logic [63:0] hdr2;

        op_rom[0]  = 5'h12; op_rom[1]  = 5'h1B;
        msg_rom[0] = 8'h01; msg_rom[1] = 8'h03; msg_rom[2] = 8'h05; msg_rom[3] = 8'h09;
        sub_rom[0] = 8'h00; sub_rom[1] = 8'h04; sub_rom[2] = 8'h02; sub_rom[3] = 8'h09;
        hdr2 = 64'h4500_0009_0802_401B;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", {63'd0, pckt_valid}, 64'd0);
        chk("rst_pckt", pckt, 64'd0);
        chk("rst_ready", {63'd0, msg_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_addrs", {58'd0, op_addr, msg_addr, sub_addr, info_addr}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1. No-data message
        b0 = beats;
        issue(2'd1, 2'd2, 1'b0, 64'd0);
        @(negedge clk);
        chk("t1_load_valid", {63'd0, pckt_valid}, 64'd0);
        chk("t1_load_ready", {63'd0, msg_ready}, 64'd0);
        chk("t1_msg_addr", {62'd0, msg_addr}, 64'd1);
        chk("t1_sub_addr", {62'd0, sub_addr}, 64'd2);
        chk("t1_op_addr", {63'd0, op_addr}, 64'd0);
        @(negedge clk);
        chk("t1_hdr_valid", {63'd0, pckt_valid}, 64'd1);
        chk("t1_hdr_pckt", pckt, 64'h0500_0002_0800_C012);
        @(negedge clk);
        chk("t1_valid_fall", {63'd0, pckt_valid}, 64'd0);
        chk("t1_ready_back", {63'd0, msg_ready}, 64'd1);
        @(posedge clk); #1;
        chk("t1_beats", beats - b0, 64'd1);

        // 2. With-data message
        b0 = beats;
        issue(2'd3, 2'd3, 1'b1, 64'h1);
        @(negedge clk);
        chk("t2_op_addr", {63'd0, op_addr}, 64'd1);
        @(negedge clk);
        chk("t2_hdr_pckt", pckt, hdr2);
        @(negedge clk);
        chk("t2_data_pckt", pckt, 64'h1);
        chk("t2_data_valid", {63'd0, pckt_valid}, 64'd1);
        @(negedge clk);
        chk("t2_valid_fall", {63'd0, pckt_valid}, 64'd0);
        @(posedge clk); #1;
        chk("t2_beats", beats - b0, 64'd2);

        // 3. Backpressure on both beats
        b0 = beats;
        pckt_ready = 1'b0;
        issue(2'd3, 2'd3, 1'b1, 64'h1);
        @(negedge clk);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hdr_hold", pckt, hdr2);
            chk("t3_hdr_valid", {63'd0, pckt_valid}, 64'd1);
            @(posedge clk); #1;
        end
        pckt_ready = 1'b1;
        @(posedge clk); #1;
        pckt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_data_hold", pckt, 64'h1);
            chk("t3_data_valid", {63'd0, pckt_valid}, 64'd1);
            @(posedge clk); #1;
        end
        pckt_ready = 1'b1;
        wait_idle();
        chk("t3_beats", beats - b0, 64'd2);

        // 4. Request while busy is ignored
        b0 = beats;
        issue(2'd0, 2'd1, 1'b0, 64'd0);
        @(posedge clk); #1;
        msg_valid = 1'b1;
        msg_sel   = 2'd2;
        @(negedge clk);
        chk("t4_ready_low", {63'd0, msg_ready}, 64'd0);
        @(posedge clk); #1;
        msg_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_no_extra", {63'd0, pckt_valid}, 64'd0);
        end
        @(posedge clk); #1;
        chk("t4_beats", beats - b0, 64'd1);

        // 5. Reset during DATA
        pckt_ready = 1'b0;
        issue(2'd3, 2'd2, 1'b1, 64'hDEAD_BEEF_0123_4567);
        @(posedge clk); #1;
        pckt_ready = 1'b1;
        @(posedge clk); #1;
        pckt_ready = 1'b0;
        @(negedge clk);
        chk("t5_in_data", pckt, 64'hDEAD_BEEF_0123_4567);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {63'd0, pckt_valid}, 64'd0);
        chk("t5_rst_pckt", pckt, 64'd0);
        chk("t5_rst_ready", {63'd0, msg_ready}, 64'd1);
        chk("t5_rst_busy", {63'd0, busy}, 64'd0);
        sb_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        pckt_ready = 1'b1;
        b0 = beats;
        issue(2'd2, 2'd1, 1'b0, 64'd0);
        wait_idle();
        chk("t5_after_beats", beats - b0, 64'd1);
        chk("t5_queue", sb_q.size(), 64'd0);

        // 6. Back-to-back, non-zero info field
        info_val = 16'hA5C3;
        b0 = beats;
        prev = 0;
        msg_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            msg_sel   = 2'(k);
            sub_sel   = 2'(3 - k);
            with_data = 1'b0;
            sb_q.push_back(exp_hdr(2'(k), 2'(3 - k), 1'b0, 64'd0));
            n = 0;
            @(negedge clk);
            while (!msg_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            #1;
            acc = cyc;
            if (k > 0) chk("t6_interval", acc - prev, 64'd3);
            prev = acc;
        end
        msg_valid = 1'b0;
        wait_idle();
        chk("t6_beats", beats - b0, 64'd4);
        chk("final_queue_empty", sb_q.size(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish");
        $fatal(1, "watchdog");
    end

endmodule
